// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl: front-end control for the chess-clock timekeeper.
// Synchronises and debounces the four panel buttons, runs the game FSM
// (idle / run P1 / run P2 / paused / over), produces the one-second tick
// and the per-player run enables, and resolves the winner from the
// timekeeper's time-up flags and the surrender buttons.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   btn_start, btn_switch_turn raw panel buttons (async, bouncy)
//   btn_surrender_p1/_p2       raw surrender buttons (async, bouncy)
//   time_up_p1/_p2             time exhausted flags (clk domain, level)
//   sec_tick                   1-cycle pulse per elapsed second of play
//   run_p1, run_p2, paused     state levels
//   game_over, winner          sticky result; winner 01 P1, 10 P2, 11 draw

// Per-button sync + debounce; rise_o pulses once per accepted 0->1 change.
module chess_clock_db #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          s1_q, s2_q, lvl_q, rise_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            rise_q <= 1'b0;
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                // DB_CYCLES consecutive differing samples: accept the change
                lvl_q  <= s2_q;
                cnt_q  <= '0;
                rise_q <= s2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;
endmodule

module chess_clock_ctrl #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_switch_turn,
    input  logic       btn_surrender_p1,
    input  logic       btn_surrender_p2,
    input  logic       time_up_p1,
    input  logic       time_up_p2,
    output logic       sec_tick,
    output logic       run_p1,
    output logic       run_p2,
    output logic       paused,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_RUN_P1, S_RUN_P2, S_PAUSED, S_OVER} state_t;

    logic [3:0] btn_raw, ev;
    assign btn_raw = {btn_surrender_p2, btn_surrender_p1, btn_switch_turn, btn_start};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        chess_clock_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_i (clk),
            .rst_i (reset),
            .btn_i (btn_raw[g]),
            .rise_o(ev[g])
        );
    end

    state_t        state_q, state_d;
    logic          resume_p2_q, resume_p2_d;  // runner to restore after pause
    logic [1:0]    win_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_d, lose1, lose2, in_play, run_now, run_next, count_en, clr;

    always_comb begin
        state_d     = state_q;
        resume_p2_d = resume_p2_q;
        win_d       = winner;
        in_play     = (state_q == S_RUN_P1) || (state_q == S_RUN_P2) || (state_q == S_PAUSED);
        lose1       = (ev[2] && in_play) || (time_up_p1 && state_q == S_RUN_P1);
        lose2       = (ev[3] && in_play) || (time_up_p2 && state_q == S_RUN_P2);
        case (state_q)
            S_IDLE: if (ev[0]) state_d = S_RUN_P1;
            S_RUN_P1, S_RUN_P2: begin
                if (lose1 || lose2) begin
                    state_d = S_OVER;
                    win_d   = {lose1, lose2};  // loser's opponent wins; both -> 11
                end else if (ev[0]) begin
                    state_d     = S_PAUSED;
                    resume_p2_d = (state_q == S_RUN_P2);
                end else if (ev[1]) begin
                    state_d = (state_q == S_RUN_P1) ? S_RUN_P2 : S_RUN_P1;
                end
            end
            S_PAUSED: begin
                if (lose1 || lose2) begin
                    state_d = S_OVER;
                    win_d   = {lose1, lose2};
                end else if (ev[0]) begin
                    state_d = resume_p2_q ? S_RUN_P2 : S_RUN_P1;
                end
            end
            default: ;
        endcase

        // Prescaler only advances while play continues into the next cycle, so
        // a switch carries the fraction over and pausing freezes it.
        run_now  = (state_q == S_RUN_P1) || (state_q == S_RUN_P2);
        run_next = (state_d == S_RUN_P1) || (state_d == S_RUN_P2);
        count_en = run_now && run_next;
        clr      = (state_q == S_IDLE) || (state_d == S_OVER);
        tick_d   = 1'b0;
        pre_d    = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (count_en) begin
            if (pre_q == PW'(CLK_DIV - 1)) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            resume_p2_q <= 1'b0;
            pre_q       <= '0;
            sec_tick    <= 1'b0;
            run_p1      <= 1'b0;
            run_p2      <= 1'b0;
            paused      <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            state_q     <= state_d;
            resume_p2_q <= resume_p2_d;
            pre_q       <= pre_d;
            sec_tick    <= tick_d;
            run_p1      <= (state_d == S_RUN_P1);
            run_p2      <= (state_d == S_RUN_P2);
            paused      <= (state_d == S_PAUSED);
            game_over   <= (state_d == S_OVER);
            winner      <= (state_d == S_OVER) ? win_d : 2'b00;
        end
    end
endmodule

// File: tb/tb_chess_clock_ctrl.sv
module tb_chess_clock_ctrl;
    localparam int CLK_DIV = 10;
    localparam int DB      = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic btn_start = 0, btn_switch_turn = 0, btn_surrender_p1 = 0, btn_surrender_p2 = 0;
    logic time_up_p1 = 0, time_up_p2 = 0;
    logic sec_tick, run_p1, run_p2, paused, game_over;
    logic [1:0] winner;

    chess_clock_ctrl #(.CLK_DIV(CLK_DIV), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_switch_turn(btn_switch_turn),
        .btn_surrender_p1(btn_surrender_p1), .btn_surrender_p2(btn_surrender_p2),
        .time_up_p1(time_up_p1), .time_up_p2(time_up_p2),
        .sec_tick(sec_tick), .run_p1(run_p1), .run_p2(run_p2),
        .paused(paused), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit cmp_en = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Game: 0 idle, 1 P1 running, 2 P2 running, 3 paused, 4 over.
    int st, resume, frac, win, tk;
    int hist1[4], hist2[4], lvl[4], dif[4], evt[4], nev[4];
    int l1, l2, nst;
    logic [3:0] raw;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st = 0; resume = 1; frac = 0; win = 0; tk = 0;
            for (int i = 0; i < 4; i++) begin
                hist1[i] = 0; hist2[i] = 0; lvl[i] = 0; dif[i] = 0; evt[i] = 0;
            end
        end else begin
            raw = {btn_surrender_p2, btn_surrender_p1, btn_switch_turn, btn_start};
            l1 = ((evt[2] != 0) && st >= 1 && st <= 3) || (time_up_p1 && st == 1);
            l2 = ((evt[3] != 0) && st >= 1 && st <= 3) || (time_up_p2 && st == 2);
            nst = st;
            if (st == 0) begin
                if (evt[0] != 0) nst = 1;
            end else if (st >= 1 && st <= 3) begin
                if (l1 || l2) begin nst = 4; win = 2 * l1 + l2; end
                else if (evt[0] != 0) begin
                    if (st == 3) nst = resume;
                    else begin resume = st; nst = 3; end
                end else if (evt[1] != 0 && st != 3) nst = 3 - st;
            end
            // elapsed-cycle count within the current second of play
            tk = 0;
            if (nst == 4 || st == 0) frac = 0;
            else if ((st == 1 || st == 2) && (nst == 1 || nst == 2)) begin
                frac = frac + 1;
                if (frac == CLK_DIV) begin frac = 0; tk = 1; end
            end
            st = nst;
            // button accepted after DB consecutive synced samples differing
            for (int i = 0; i < 4; i++) begin
                nev[i] = 0;
                if (hist2[i] != lvl[i]) begin
                    dif[i] = dif[i] + 1;
                    if (dif[i] == DB) begin lvl[i] = hist2[i]; dif[i] = 0; nev[i] = lvl[i]; end
                end else dif[i] = 0;
                hist2[i] = hist1[i];
                hist1[i] = raw[i];
                evt[i] = nev[i];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_tick", sec_tick, tk);
            chk("m_run1", run_p1, st == 1);
            chk("m_run2", run_p2, st == 2);
            chk("m_pause", paused, st == 3);
            chk("m_over", game_over, st == 4);
            chk("m_win", winner, win);
        end
    end

    // ---------------- helpers ----------------
    task automatic set_in(logic [5:0] v);
        {time_up_p2, time_up_p1, btn_surrender_p2, btn_surrender_p1, btn_switch_turn, btn_start} = v;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 1;
        @(posedge clk); #2 reset = 0;
    endtask

    task automatic pulse(logic [5:0] v, int len);
        @(negedge clk); set_in(v);
        repeat (len) @(negedge clk);
        set_in(6'd0);
        repeat (14) @(negedge clk);
    endtask

    task automatic chk_out(string nm, int r1, int r2, int p, int o, int w);
        chk({nm, "_run1"}, run_p1, r1);
        chk({nm, "_run2"}, run_p2, r2);
        chk({nm, "_paused"}, paused, p);
        chk({nm, "_over"}, game_over, o);
        chk({nm, "_win"}, winner, w);
    endtask

    typedef struct {
        logic [5:0] in;   // {tu2,tu1,s2,s1,sw,start}
        int len;
        int r1, r2, p, o, w;
    } vec_t;

    vec_t tbl[12];
    int hold[6];
    logic [5:0] rin;

    initial begin
        tbl[0]  = '{6'b000010, 3,  1, 0, 0, 0, 0};  // glitch switch
        tbl[1]  = '{6'b000010, 10, 0, 1, 0, 0, 0};  // switch -> P2
        tbl[2]  = '{6'b000001, 6,  0, 0, 1, 0, 0};  // pause
        tbl[3]  = '{6'b000010, 10, 0, 0, 1, 0, 0};  // switch ignored in pause
        tbl[4]  = '{6'b000001, 6,  0, 1, 0, 0, 0};  // resume P2
        tbl[5]  = '{6'b010000, 5,  0, 1, 0, 0, 0};  // P1 time up while P2 runs
        tbl[6]  = '{6'b000010, 6,  1, 0, 0, 0, 0};  // switch -> P1
        tbl[7]  = '{6'b100000, 5,  1, 0, 0, 0, 0};  // P2 time up while P1 runs
        tbl[8]  = '{6'b010000, 3,  0, 0, 0, 1, 2};  // P1 time up -> P2 wins
        tbl[9]  = '{6'b000001, 6,  0, 0, 0, 1, 2};
        tbl[10] = '{6'b001000, 6,  0, 0, 0, 1, 2};
        tbl[11] = '{6'b000010, 6,  0, 0, 0, 1, 2};

        set_in(6'd0);
        repeat (3) @(negedge clk);
        reset = 0;
        cmp_en = 1;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset_tick", sec_tick, 0);

        // start latency and tick cadence; edge k=0 is the first sample of the press
        @(negedge clk); btn_start = 1;
        for (int k = 0; k <= 36; k++) begin
            @(posedge clk); #1;
            if (k <= 7) chk($sformatf("lat_run1_e%0d", k), run_p1, k >= 6);
            if (k >= 6) chk($sformatf("lat_tick_e%0d", k), sec_tick, (k == 16 || k == 26 || k == 36));
            if (k == 19) btn_start = 0;
        end
        chk_out("t1", 1, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            pulse(tbl[i].in, tbl[i].len);
            chk_out($sformatf("tbl%0d", i), tbl[i].r1, tbl[i].r2, tbl[i].p, tbl[i].o, tbl[i].w);
        end

        // simultaneous surrender -> draw
        do_reset();
        pulse(6'b000001, 6);
        pulse(6'b001100, 6);
        chk_out("draw", 0, 0, 0, 1, 3);

        // surrender of P2 while paused -> P1 wins
        do_reset();
        pulse(6'b000001, 6);
        pulse(6'b000001, 6);
        chk_out("pause_pre", 0, 0, 1, 0, 0);
        pulse(6'b001000, 6);
        chk_out("pause_sur", 0, 0, 0, 1, 1);

        // asynchronous reset mid RUN_P2
        do_reset();
        pulse(6'b000001, 6);
        pulse(6'b000010, 8);
        chk("ar_pre_run2", run_p2, 1);
        @(posedge clk); #3 reset = 1;
        #1;
        chk_out("ar", 0, 0, 0, 0, 0);
        chk("ar_tick", sec_tick, 0);
        repeat (2) @(posedge clk);
        #2 reset = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("ar_idle_tick", sec_tick, 0);
            chk("ar_idle_run1", run_p1, 0);
        end

        // randomized games against the model
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int j = 0; j < 6; j++) hold[j] = 0;
            rin = '0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                for (int j = 0; j < 4; j++) begin
                    if (hold[j] == 0) begin
                        rin[j] = (j < 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                        hold[j] = $urandom_range(1, 12);
                    end else hold[j]--;
                end
                rin[4] = ($urandom_range(0, 99) < 2);
                rin[5] = ($urandom_range(0, 99) < 2);
                set_in(rin);
            end
            set_in(6'd0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
